posit_decoder: RTL and testbench
================================

POSIT_DECODER -- requirements
Module: posit_decoder

Interface
REQ-001 Parameter N, default 32: posit word width; the only supported value.
REQ-002 Parameter ES, default 3: exponent field width; the only supported value.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  request to decode p_in; sampled only in IDLE.
REQ-006 p_in  input  32  posit word to decode.
REQ-007 sign_out  output  1  posit sign bit.
REQ-008 k_out  output  6  signed regime value, range -30..+30.
REQ-009 exp_out  output  3  exponent field; MSB is the first exponent bit.
REQ-010 mantissa_out  output  32  fraction bits left-aligned, hidden bit excluded; unused LSBs zero.
REQ-011 zero  output  1  input was 0x00000000.
REQ-012 nar  output  1  input was 0x80000000.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse; all result outputs are valid from this cycle onward.

Function
REQ-015 FSM states: IDLE, SIGN, REGIME, EXP, MANT, DONE; state encoding lives in the package.
REQ-016 IDLE with start=1: latch p_in; clear k_out, exp_out, mantissa_out, zero and nar; load index=30; go to SIGN.
REQ-017 SIGN state:
- sign_out = latched bit 31.
- If bit 31 is 1, replace the working word with its two's complement.
- Special cases: 0x00000000 sets zero; 0x80000000 sets nar; either jumps to DONE.
- Otherwise record bit 30 of the working word as the regime bit and go to REGIME.
REQ-018 Bit consumption: REGIME, EXP and MANT each consume working bit [index], one bit per cycle, then decrement index.
REQ-019 REGIME run of m bits equal to the regime bit:
- Regime bit 1 gives k_out = m-1.
- Regime bit 0 gives k_out = -m.
- The first opposite bit is the terminator; it is consumed, then the FSM goes to EXP.
REQ-020 If the run reaches index 0 with no terminator, decoding ends after bit 0: exp_out and mantissa_out stay 0.
REQ-021 EXP shifts up to 3 bits into exp_out, MSB first; bits past index 0 are zero; after 3 bits go to MANT.
REQ-022 MANT writes bit [index] to mantissa_out[31-j] for j = 0,1,...; after consuming index 0, go to DONE.
REQ-023 Non-special latency: the FSM processes exactly 31 bit cycles, so done is high in the cycle after the 33rd rising edge following the start-sampling edge.
REQ-024 Special-case latency (zero/NaR): done is high after the 2nd edge following the start-sampling edge.
REQ-025 DONE: assert done for one cycle, then return to IDLE; result outputs hold until the next accepted start.
REQ-026 start is ignored while busy; p_in changes after the start-sampling edge do not affect the result.
REQ-027 Arithmetic widths: index is 5 bits and never wraps below 0; the run counter is 6 bits.

Reset
REQ-028 With rst=0 at a rising edge: state = IDLE, index = 30, all outputs 0.
REQ-029 Reset mid-decode aborts the decode; no done pulse follows; the next start after reset release decodes normally.

Structure
REQ-030 The shared posit package holds N, ES, k width (6), the ZERO and NAR word constants, and the FSM state encoding; the downstream posit encoder uses the same package.
REQ-031 The block is a single module with no sub-module.
REQ-032 sign_out, k_out, exp_out and mantissa_out are port-compatible with the posit encoder inputs, so the decoder can be chained directly into it.

Verification
REQ-033 p_in=0x40000000 -> sign 0, k 0, exp 0, mantissa 0x00000000, done after edge 33.
REQ-034 p_in=0x4B400000 -> sign 0, k 0, exp 2, mantissa 0xD0000000.
REQ-035 p_in=0xC0000000 -> sign 1, k 0, exp 0, mantissa 0; p_in=0x00000001 -> sign 0, k -30, exp 0, mantissa 0.
REQ-036 p_in=0x7FFFFFFF -> sign 0, k 30, exp 0, mantissa 0, done after edge 33.
REQ-037 p_in=0x00000000 -> zero=1, done after edge 2; p_in=0x80000000 -> nar=1, done after edge 2.
REQ-038 Reset and handshake scenario:
- Drive rst=0 at edge 10 of a decode -> no done pulse, all outputs 0.
- A start pulse while busy -> ignored.
- Round trip: decoder output fed to the posit encoder reproduces p_in for random non-special words.

Source files
------------

// File: rtl/posit_decoder_pkg.sv
// posit_decoder_pkg: shared posit(32,3) widths, special words and decoder FSM encoding
package posit_decoder_pkg;
  localparam int POSIT_N = 32;
  localparam int POSIT_ES = 3;
  localparam int KW = 6;
  localparam logic [POSIT_N-1:0] ZERO = '0;
  localparam logic [POSIT_N-1:0] NAR = {1'b1, {(POSIT_N-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, SIGN, REGIME, EXP, MANT, DONE} state_t;
endpackage

// File: rtl/posit_decoder.sv
// posit_decoder: serial one-bit-per-cycle posit(32,3) field decoder
module posit_decoder
  import posit_decoder_pkg::*;
#(
  parameter int N = POSIT_N,
  parameter int ES = POSIT_ES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N-1:0]         p_in,
  output logic                 sign_out,
  output logic signed [KW-1:0] k_out,
  output logic [ES-1:0]        exp_out,
  output logic [N-1:0]         mantissa_out,
  output logic                 zero,
  output logic                 nar,
  output logic                 busy,
  output logic                 done
);
  state_t state, state_n;
  logic [N-1:0] w, wc;
  logic [4:0] idx, idx_n, j;
  logic [KW-1:0] run, run_n;
  logic [1:0] ecnt;
  logic r, b, last;
  assign wc = w[N-1] ? -w : w;
  assign b = w[idx];
  assign last = idx == 5'd0;
  assign idx_n = last ? idx : idx - 5'd1;
  assign run_n = run + {{(KW-1){1'b0}}, b == r};
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SIGN : IDLE;
      SIGN:    state_n = (w == ZERO || w == NAR) ? DONE : REGIME;
      REGIME:  state_n = last ? DONE : (b != r ? EXP : REGIME);
      EXP:     state_n = last ? DONE : (ecnt == 2'd2 ? MANT : EXP);
      MANT:    state_n = last ? DONE : MANT;
      default: state_n = IDLE;
    endcase
  end
  // exponent and fraction bits land at fixed positions so an early end leaves zeros below
  always_ff @(posedge clk) begin
    if (!rst) begin
      w <= '0;
      idx <= 5'd30;
      j <= '0;
      run <= '0;
      ecnt <= '0;
      r <= 1'b0;
      sign_out <= 1'b0;
      k_out <= '0;
      exp_out <= '0;
      mantissa_out <= '0;
      zero <= 1'b0;
      nar <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          w <= p_in;
          idx <= 5'd30;
          j <= '0;
          run <= '0;
          ecnt <= '0;
          k_out <= '0;
          exp_out <= '0;
          mantissa_out <= '0;
          zero <= 1'b0;
          nar <= 1'b0;
        end
        SIGN: begin
          sign_out <= w[N-1];
          w <= wc;
          zero <= w == ZERO;
          nar <= w == NAR;
          r <= wc[N-2];
        end
        REGIME: begin
          run <= run_n;
          k_out <= r ? run_n - {{(KW-1){1'b0}}, 1'b1} : -run_n;
          idx <= idx_n;
        end
        EXP: begin
          exp_out[2'(ES-1) - ecnt] <= b;
          ecnt <= ecnt + 2'd1;
          idx <= idx_n;
        end
        MANT: begin
          mantissa_out[5'(N-1) - j] <= b;
          j <= j + 5'd1;
          idx <= idx_n;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_posit_decoder.sv
// tb_posit_decoder: directed and random decode checks against an arithmetic posit model
module tb_posit_decoder;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0] p_in = '0;
  logic sign_out, zero, nar, busy, done;
  logic signed [5:0] k_out;
  logic [2:0] exp_out;
  logic [31:0] mantissa_out;
  int checks = 0, failures = 0;
  typedef struct {
    logic [31:0] p;
    logic s;
    int k;
    logic [2:0] e;
    logic [31:0] m;
  } vec_t;
  vec_t dv[9] = '{
    '{32'h4000_0000, 1'b0,   0, 3'd0, 32'h0000_0000},
    '{32'h4B40_0000, 1'b0,   0, 3'd2, 32'hD000_0000},
    '{32'hC000_0000, 1'b1,   0, 3'd0, 32'h0000_0000},
    '{32'h0000_0001, 1'b0, -30, 3'd0, 32'h0000_0000},
    '{32'h7FFF_FFFF, 1'b0,  30, 3'd0, 32'h0000_0000},
    '{32'h7FFF_FFFE, 1'b0,  29, 3'd0, 32'h0000_0000},
    '{32'h0000_0003, 1'b0, -29, 3'd4, 32'h0000_0000},
    '{32'h0000_0000, 1'b0,   0, 3'd0, 32'h0000_0000},
    '{32'h8000_0000, 1'b1,   0, 3'd0, 32'h0000_0000}
  };

  posit_decoder dut (
    .clk(clk), .rst(rst), .start(start), .p_in(p_in),
    .sign_out(sign_out), .k_out(k_out), .exp_out(exp_out),
    .mantissa_out(mantissa_out), .zero(zero), .nar(nar),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // regime run measured from the magnitude, remaining bits taken as a left-aligned tail
  task automatic ref_decode(input logic [31:0] p, output logic s, output int k,
                            output logic [2:0] e, output logic [31:0] m);
    logic [31:0] a, t;
    int i, run;
    s = p[31];
    a = s ? -p : p;
    run = 0;
    i = 30;
    while (i >= 0 && a[i] == a[30]) begin
      run++;
      i--;
    end
    k = a[30] ? run - 1 : -run;
    i--;
    t = (i >= 0) ? a << (31 - i) : 32'd0;
    e = t[31:29];
    m = t << 3;
  endtask

  function automatic logic [31:0] ref_encode(logic s, int k, logic [2:0] e, logic [31:0] m);
    logic [127:0] v;
    logic [31:0] body;
    int len;
    if (k >= 0) begin
      v = ((128'd1 << (k + 1)) - 128'd1) << 1;
      len = k + 2;
    end else begin
      v = 128'd1;
      len = 1 - k;
    end
    v = (v << 35) | {93'd0, e, m};
    v = v >> (len + 4);
    body = {1'b0, v[30:0]};
    return s ? -body : body;
  endfunction

  task automatic run_dec(input logic [31:0] p, input bit poke);
    logic s;
    int k, lat;
    logic [2:0] e;
    logic [31:0] m;
    bit sp;
    ref_decode(p, s, k, e, m);
    sp = (p == 32'h0) || (p == 32'h8000_0000);
    if (sp) begin
      k = 0;
      e = '0;
      m = '0;
    end
    @(negedge clk);
    p_in = p;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    p_in = $urandom;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      if (poke && n == 5) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (done) lat = n;
    end
    chk("latency", lat, sp ? 32'd2 : 32'd33);
    chk("sign", {31'd0, sign_out}, {31'd0, s});
    chk("k", 32'(k_out), k);
    chk("exp", {29'd0, exp_out}, {29'd0, e});
    chk("mant", mantissa_out, m);
    chk("zero", {31'd0, zero}, {31'd0, p == 32'h0});
    chk("nar", {31'd0, nar}, {31'd0, p == 32'h8000_0000});
    if (!sp) chk("round_trip", ref_encode(sign_out, int'(k_out), exp_out, mantissa_out), p);
    @(posedge clk);
    #1 chk("done_pulse", {31'd0, done}, 32'd0);
    chk("mant_hold", mantissa_out, m);
  endtask

  initial begin
    int dseen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_outs", {sign_out, zero, nar, 29'd0}, 32'd0);
    chk("rst_k", 32'(k_out), 32'd0);
    chk("rst_mant", mantissa_out, 32'd0);
    rst = 1'b1;
    foreach (dv[i]) begin
      run_dec(dv[i].p, i[0]);
      chk("dir_sign", {31'd0, sign_out}, {31'd0, dv[i].s});
      chk("dir_k", 32'(k_out), dv[i].k);
      chk("dir_exp", {29'd0, exp_out}, {29'd0, dv[i].e});
      chk("dir_mant", mantissa_out, dv[i].m);
    end
    // reset sampled at the 10th edge of a decode must abort it silently
    @(negedge clk);
    p_in = 32'h4B40_0000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_outs", {sign_out, zero, nar, done, exp_out, 25'd0}, 32'd0);
    chk("abort_k", 32'(k_out), 32'd0);
    chk("abort_mant", mantissa_out, 32'd0);
    rst = 1'b1;
    dseen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) dseen++;
    end
    chk("abort_no_done", dseen, 32'd0);
    run_dec(32'h4B40_0000, 1'b0);
    repeat (40) run_dec($urandom, 1'($urandom_range(0, 1)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
